// File: rtl/mux4_rr_sel_gen.sv
// mux4_rr_sel_gen: round-robin burst select generator for the mux_4_1 select pins
module mux4_rr_sel_gen #(
    parameter int BURST = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       ready,
    output logic       sel0,
    output logic       sel1,
    output logic [3:0] gnt,
    output logic       valid,
    output logic       last
);
    typedef enum logic {IDLE, GRANT} state_t;
    localparam logic [3:0] LAST = 4'(BURST - 1);
    state_t     state, state_n;
    logic [1:0] cur, cur_n, ptr, ptr_n, sp, hit_idx;
    logic [3:0] cnt, cnt_n;
    logic       hit, acc, rel;

    function automatic logic [2:0] search(input logic [3:0] r, input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] k;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            k = p + 2'(i);
            if (r[k]) res = {1'b1, k};
        end
        return res;
    endfunction

    // Next grant: a release in GRANT (or any request in IDLE) re-runs the search from cur+1 (or ptr)
    always_comb begin
        sp             = (state == GRANT) ? cur + 2'd1 : ptr;
        {hit, hit_idx} = search(req, sp);
        acc            = (state == GRANT) && ready;
        rel            = (state == IDLE) || (acc && cnt == LAST) || !req[cur];
        ptr_n          = (state == GRANT && rel) ? cur + 2'd1 : ptr;
        state_n        = rel ? (hit ? GRANT : IDLE) : state;
        cur_n          = (rel && hit) ? hit_idx : cur;
        cnt_n          = (rel && hit) ? 4'd0 : cnt + 4'(acc);
    end

    // State and registered outputs; cur doubles as the held select value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cur   <= 2'd0;
            ptr   <= 2'd0;
            cnt   <= 4'd0;
            gnt   <= 4'b0000;
        end else begin
            state <= state_n;
            cur   <= cur_n;
            ptr   <= ptr_n;
            cnt   <= cnt_n;
            gnt   <= (state_n == GRANT) ? 4'b0001 << cur_n : 4'b0000;
        end
    end

    assign sel0  = cur[1];
    assign sel1  = cur[0];
    assign valid = (state == GRANT);
    assign last  = valid && (cnt == LAST);
endmodule

// File: tb/tb_mux4_rr_sel_gen.sv
// tb_mux4_rr_sel_gen: scoreboard bench for the round-robin select generator
module tb_mux4_rr_sel_gen;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] req = 4'b0000;
    logic       ready = 1'b0;
    logic       sel0, sel1, valid, last;
    logic [3:0] gnt;
    logic [6:0] sb[$];
    int         errors = 0;
    int         checks = 0;

    mux4_rr_sel_gen #(.BURST(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .ready(ready),
        .sel0(sel0), .sel1(sel1), .gnt(gnt), .valid(valid), .last(last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic [3:0] r, input logic rd);
        req   = r;
        ready = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] s, input logic l);
        logic [3:0] g;
        g = 4'b0001 << s;
        sb.push_back({s, g, l});
    endtask

    task automatic outs(input string name, input logic v, input logic [1:0] s, input logic [3:0] g, input logic l);
        chk({name, ".valid"}, int'(valid), int'(v));
        chk({name, ".sel"}, int'({sel0, sel1}), int'(s));
        chk({name, ".gnt"}, int'(gnt), int'(g));
        chk({name, ".last"}, int'(last), int'(l));
    endtask

    // Monitor: every accepted beat must match the next expected beat
    always @(negedge clk) begin
        if (rst_n && valid && ready) begin
            if (sb.size() == 0) chk("unexpected_beat", int'({sel0, sel1, gnt, last}), 0);
            else begin
                logic [6:0] e;
                e = sb.pop_front();
                chk("beat", int'({sel0, sel1, gnt, last}), int'(e));
            end
        end
    end

    initial begin
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        outs("reset", 1'b0, 2'b00, 4'b0000, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // single requester on channel 2
        cyc(4'b0100, 1'b1);
        outs("single_first", 1'b1, 2'b10, 4'b0100, 1'b0);
        for (int i = 0; i < 8; i++) push(2'b10, i % 4 == 3);
        for (int i = 0; i < 8; i++) begin
            cyc(4'b0100, 1'b1);
            chk("single_valid", int'(valid), 1);
        end
        cyc(4'b0000, 1'b0);
        outs("single_idle", 1'b0, 2'b10, 4'b0000, 1'b0);

        // asynchronous reset in the middle of a grant (ptr=3 -> channel 3)
        cyc(4'b1111, 1'b0);
        outs("pre_reset", 1'b1, 2'b11, 4'b1000, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        outs("async_reset", 1'b0, 2'b00, 4'b0000, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // full rotation starting at channel 0
        cyc(4'b1111, 1'b1);
        outs("rot_first", 1'b1, 2'b00, 4'b0001, 1'b0);
        for (int i = 0; i < 17; i++) push(2'(i / 4), i % 4 == 3);
        for (int i = 0; i < 17; i++) cyc(4'b1111, 1'b1);
        cyc(4'b0000, 1'b0);
        chk("rot_idle.valid", int'(valid), 0);

        // stall after beat 2 of channel 1, then channel 2 follows
        cyc(4'b0110, 1'b1);
        push(2'b01, 1'b0);
        push(2'b01, 1'b0);
        cyc(4'b0110, 1'b1);
        cyc(4'b0110, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(4'b0110, 1'b0);
            outs("stall_hold", 1'b1, 2'b01, 4'b0010, 1'b0);
        end
        push(2'b01, 1'b0);
        push(2'b01, 1'b1);
        cyc(4'b0110, 1'b1);
        cyc(4'b0110, 1'b1);
        outs("stall_next", 1'b1, 2'b10, 4'b0100, 1'b0);
        cyc(4'b0000, 1'b0);
        chk("stall_idle.valid", int'(valid), 0);

        // withdrawal of channel 3 while stalled hands over to channel 0
        cyc(4'b1000, 1'b0);
        outs("wd_grant", 1'b1, 2'b11, 4'b1000, 1'b0);
        cyc(4'b0001, 1'b0);
        outs("wd_next", 1'b1, 2'b00, 4'b0001, 1'b0);
        for (int i = 0; i < 4; i++) push(2'b00, i == 3);
        for (int i = 0; i < 4; i++) cyc(4'b0001, 1'b1);

        // early end: req[0] drops together with the accept of beat 2
        push(2'b00, 1'b0);
        push(2'b00, 1'b0);
        cyc(4'b0001, 1'b1);
        cyc(4'b0000, 1'b1);
        outs("early_end", 1'b0, 2'b00, 4'b0000, 1'b0);
        cyc(4'b0000, 1'b0);
        cyc(4'b0000, 1'b0);
        chk("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
